// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-port LSU-to-system-bus arbiter.
// Round-robin arbitration is selected with the CPU_ARB_RR_EN macro.
package mem_bus_arbiter_pkg;

    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;
    localparam int NUM_PORTS      = 2;

    localparam logic [1:0] CPU_LSU_IDLE  = 2'd0;
    localparam logic [1:0] CPU_LSU_BYTE  = 2'd1;
    localparam logic [1:0] CPU_LSU_HWORD = 2'd2;
    localparam logic [1:0] CPU_LSU_WORD  = 2'd3;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        CPU_ARB_IDLE  = 2'd0,
        CPU_ARB_BUS_F = 2'd1,
        CPU_ARB_BUS_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0] addr;
        logic [CPU_DATA_WIDTH-1:0] wdata;
        logic [1:0]                cmd;
        logic                      rnw;
    } lsu_req_t;

    function automatic logic lsu_misaligned(input logic [1:0] cmd, input logic [1:0] addr_lo);
        return ((cmd == CPU_LSU_HWORD) && addr_lo[0]) ||
               ((cmd == CPU_LSU_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// System bus seen by the arbiter: req/ack handshake with word address,
// byte enables and lane-replicated write data.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic                      req;
    logic [CPU_ADDR_WIDTH-1:0] addr;
    logic [3:0]                be;
    logic                      rnw;
    logic [CPU_DATA_WIDTH-1:0] wdata;
    logic                      ack;
    logic [CPU_DATA_WIDTH-1:0] rdata;
    logic                      err;

    modport master (
        output req, addr, be, rnw, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, addr, be, rnw, wdata,
        output ack, rdata, err
    );

endinterface

// File: rtl/mem_bus_arbiter_bus_lane_align.sv
// Little-endian byte-lane steering: byte enables and replicated write data
// toward the bus, right-aligned and zero-extended read data back.
module mem_bus_arbiter_bus_lane_align
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0]                cmd,
    input  logic [1:0]                addr_lo,
    input  logic [CPU_DATA_WIDTH-1:0] wdata,
    input  logic [CPU_DATA_WIDTH-1:0] bus_rdata,
    output logic [3:0]                be,
    output logic [CPU_DATA_WIDTH-1:0] bus_wdata,
    output logic [CPU_DATA_WIDTH-1:0] rdata
);

    logic [CPU_DATA_WIDTH-1:0] byte_rep;
    logic [CPU_DATA_WIDTH-1:0] half_rep;
    logic [CPU_DATA_WIDTH-1:0] shifted;

    // Narrow stores appear on every lane so the slave can pick by byte enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign byte_rep[8*gi +: 8] = wdata[7:0];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign half_rep[16*gi +: 16] = wdata[15:0];
    end

    assign shifted = bus_rdata >> {addr_lo, 3'b000};

    always_comb begin
        be        = 4'b0000;
        bus_wdata = '0;
        rdata     = '0;
        case (cmd)
            CPU_LSU_BYTE: begin
                be        = 4'b0001 << addr_lo;
                bus_wdata = byte_rep;
                rdata     = {24'd0, shifted[7:0]};
            end
            CPU_LSU_HWORD: begin
                be        = 4'b0011 << addr_lo;
                bus_wdata = half_rep;
                rdata     = {16'd0, shifted[15:0]};
            end
            CPU_LSU_WORD: begin
                be        = 4'b1111;
                bus_wdata = wdata;
                rdata     = shifted;
            end
            default: begin
                be        = 4'b0000;
                bus_wdata = '0;
                rdata     = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack system bus between the fetch (f) and data (d) LSU ports.
// Define CPU_ARB_RR_EN for round-robin; otherwise the data port has priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      nrst,

    input  logic [CPU_ADDR_WIDTH-1:0] i_f_addr,
    input  logic [CPU_DATA_WIDTH-1:0] i_f_wdata,
    input  logic [1:0]                i_f_cmd,
    input  logic                      i_f_rnw,
    output logic [CPU_DATA_WIDTH-1:0] o_f_rdata,
    output logic                      o_f_busy,
    output logic                      o_f_err_align,
    output logic                      o_f_err_bus,

    input  logic [CPU_ADDR_WIDTH-1:0] i_d_addr,
    input  logic [CPU_DATA_WIDTH-1:0] i_d_wdata,
    input  logic [1:0]                i_d_cmd,
    input  logic                      i_d_rnw,
    output logic [CPU_DATA_WIDTH-1:0] o_d_rdata,
    output logic                      o_d_busy,
    output logic                      o_d_err_align,
    output logic                      o_d_err_bus,

    mem_bus_arbiter_if.master         bus
);

    logic [CPU_ADDR_WIDTH-1:0] addr_in  [NUM_PORTS];
    logic [CPU_DATA_WIDTH-1:0] wdata_in [NUM_PORTS];
    logic [1:0]                cmd_in   [NUM_PORTS];
    logic                      rnw_in   [NUM_PORTS];

    lsu_req_t                  port_lat       [NUM_PORTS];
    logic                      port_pend      [NUM_PORTS];
    logic [CPU_DATA_WIDTH-1:0] port_rdata     [NUM_PORTS];
    logic                      port_err_align [NUM_PORTS];
    logic                      port_err_bus   [NUM_PORTS];
    logic                      done           [NUM_PORTS];

    arb_state_e                state_q, state_d;
    logic                      bus_req_q, bus_req_d;
    logic [CPU_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]                bus_be_q, bus_be_d;
    logic                      bus_rnw_q, bus_rnw_d;
    logic [CPU_DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
`ifdef CPU_ARB_RR_EN
    logic                      last_q, last_d;
`endif

    logic                      grant_port;
    logic                      sel_port;
    lsu_req_t                  sel_lat;
    logic [3:0]                lane_be;
    logic [CPU_DATA_WIDTH-1:0] lane_wdata;
    logic [CPU_DATA_WIDTH-1:0] lane_rdata;

    assign addr_in[PORT_F]  = i_f_addr;
    assign wdata_in[PORT_F] = i_f_wdata;
    assign cmd_in[PORT_F]   = i_f_cmd;
    assign rnw_in[PORT_F]   = i_f_rnw;
    assign addr_in[PORT_D]  = i_d_addr;
    assign wdata_in[PORT_D] = i_d_wdata;
    assign cmd_in[PORT_D]   = i_d_cmd;
    assign rnw_in[PORT_D]   = i_d_rnw;

    assign done[PORT_F] = (state_q == CPU_ARB_BUS_F) && bus.ack;
    assign done[PORT_D] = (state_q == CPU_ARB_BUS_D) && bus.ack;

    // Per-port request latch, error pulses and read-data holding register.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        lsu_req_t                  lat_q, lat_d;
        logic                      pend_q, pend_d;
        logic [CPU_DATA_WIDTH-1:0] rdata_q, rdata_d;
        logic                      err_align_q, err_align_d;
        logic                      err_bus_q, err_bus_d;
        logic                      accept;
        logic                      misaligned;

        always_comb begin
            // A command while already pending is dropped rather than queued.
            accept      = (cmd_in[gi] != CPU_LSU_IDLE) && !pend_q;
            misaligned  = lsu_misaligned(cmd_in[gi], addr_in[gi][1:0]);
            lat_d       = lat_q;
            pend_d      = pend_q;
            rdata_d     = rdata_q;
            err_align_d = accept && misaligned;
            err_bus_d   = done[gi] && bus.err;
            if (done[gi]) begin
                pend_d = 1'b0;
                if (lat_q.rnw && !bus.err) begin
                    rdata_d = lane_rdata;
                end
            end
            if (accept && !misaligned) begin
                pend_d      = 1'b1;
                lat_d.addr  = addr_in[gi];
                lat_d.wdata = wdata_in[gi];
                lat_d.cmd   = cmd_in[gi];
                lat_d.rnw   = rnw_in[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (!nrst) begin
                lat_q       <= '0;
                pend_q      <= 1'b0;
                rdata_q     <= '0;
                err_align_q <= 1'b0;
                err_bus_q   <= 1'b0;
            end else begin
                lat_q       <= lat_d;
                pend_q      <= pend_d;
                rdata_q     <= rdata_d;
                err_align_q <= err_align_d;
                err_bus_q   <= err_bus_d;
            end
        end

        assign port_lat[gi]       = lat_q;
        assign port_pend[gi]      = pend_q;
        assign port_rdata[gi]     = rdata_q;
        assign port_err_align[gi] = err_align_q;
        assign port_err_bus[gi]   = err_bus_q;
    end

    always_comb begin
`ifdef CPU_ARB_RR_EN
        if (port_pend[PORT_F] && port_pend[PORT_D]) begin
            grant_port = ~last_q;
        end else begin
            grant_port = port_pend[PORT_D] ? PORT_D : PORT_F;
        end
`else
        grant_port = port_pend[PORT_D] ? PORT_D : PORT_F;
`endif
        // The aligner serves the port about to be granted in IDLE, and the
        // active port during a bus cycle so read data can be steered on ack.
        if (state_q == CPU_ARB_IDLE) begin
            sel_port = grant_port;
        end else begin
            sel_port = (state_q == CPU_ARB_BUS_D) ? PORT_D : PORT_F;
        end
    end

    assign sel_lat = port_lat[sel_port];

    mem_bus_arbiter_bus_lane_align u_lane_align (
        .cmd       (sel_lat.cmd),
        .addr_lo   (sel_lat.addr[1:0]),
        .wdata     (sel_lat.wdata),
        .bus_rdata (bus.rdata),
        .be        (lane_be),
        .bus_wdata (lane_wdata),
        .rdata     (lane_rdata)
    );

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_rnw_d   = bus_rnw_q;
        bus_wdata_d = bus_wdata_q;
`ifdef CPU_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            CPU_ARB_IDLE: begin
                if (port_pend[PORT_F] || port_pend[PORT_D]) begin
                    state_d     = (grant_port == PORT_D) ? CPU_ARB_BUS_D : CPU_ARB_BUS_F;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = {sel_lat.addr[CPU_ADDR_WIDTH-1:2], 2'b00};
                    bus_be_d    = lane_be;
                    bus_rnw_d   = sel_lat.rnw;
                    bus_wdata_d = lane_wdata;
`ifdef CPU_ARB_RR_EN
                    last_d      = grant_port;
`endif
                end
            end
            CPU_ARB_BUS_F, CPU_ARB_BUS_D: begin
                // Always returning through IDLE keeps req low for a cycle after ack.
                if (bus.ack) begin
                    state_d   = CPU_ARB_IDLE;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = CPU_ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= CPU_ARB_IDLE;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_rnw_q   <= 1'b0;
            bus_wdata_q <= '0;
`ifdef CPU_ARB_RR_EN
            last_q      <= PORT_F;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_rnw_q   <= bus_rnw_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef CPU_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.req   = bus_req_q;
    assign bus.addr  = bus_addr_q;
    assign bus.be    = bus_be_q;
    assign bus.rnw   = bus_rnw_q;
    assign bus.wdata = bus_wdata_q;

    assign o_f_busy      = (i_f_cmd != CPU_LSU_IDLE) || port_pend[PORT_F];
    assign o_d_busy      = (i_d_cmd != CPU_LSU_IDLE) || port_pend[PORT_D];
    assign o_f_rdata     = port_rdata[PORT_F];
    assign o_d_rdata     = port_rdata[PORT_D];
    assign o_f_err_align = port_err_align[PORT_F];
    assign o_d_err_align = port_err_align[PORT_D];
    assign o_f_err_bus   = port_err_bus[PORT_F];
    assign o_d_err_bus   = port_err_bus[PORT_D];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table on both LSU ports,
// a scripted bus slave, and hand sequences for contention and reset abort.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        logic        port;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rnw;
        logic [31:0] bus_word;
        int          waits;
        logic        bus_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_bus_wdata;
        logic [31:0] exp_rdata;
        logic        exp_align;
        logic        exp_bus_err;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        rnw;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        align;
        logic        bus_err;
        int          busy;
    } res_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [31:0] f_addr = '0, f_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [1:0]  f_cmd = CPU_LSU_IDLE, d_cmd = CPU_LSU_IDLE;
    logic        f_rnw = 1'b0, d_rnw = 1'b0;
    logic [31:0] f_rdata, d_rdata;
    logic        f_busy, d_busy, f_err_align, d_err_align, f_err_bus, d_err_bus;

    mem_bus_arbiter_if bus_if();

    mem_bus_arbiter dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_f_addr      (f_addr),
        .i_f_wdata     (f_wdata),
        .i_f_cmd       (f_cmd),
        .i_f_rnw       (f_rnw),
        .o_f_rdata     (f_rdata),
        .o_f_busy      (f_busy),
        .o_f_err_align (f_err_align),
        .o_f_err_bus   (f_err_bus),
        .i_d_addr      (d_addr),
        .i_d_wdata     (d_wdata),
        .i_d_cmd       (d_cmd),
        .i_d_rnw       (d_rnw),
        .o_d_rdata     (d_rdata),
        .o_d_busy      (d_busy),
        .o_d_err_align (d_err_align),
        .o_d_err_bus   (d_err_bus),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bus_exp_t bus_q[$];
    res_t     res_f[$];
    res_t     res_d[$];

    logic        slave_en = 1'b1;
    int          slave_waits = 0;
    logic [31:0] slave_word = '0;
    logic        slave_err = 1'b0;
    logic        force_ack = 1'b0;
    logic        force_err = 1'b0;
    logic [31:0] force_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Bus slave: acks after slave_waits cycles of req, checks the request
    // against the scoreboard when it acks.
    initial begin
        int   wcnt;
        logic prev_ack;
        bus_exp_t e;
        wcnt = 0;
        prev_ack = 1'b0;
        bus_if.ack = 1'b0;
        bus_if.rdata = '0;
        bus_if.err = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!slave_en) begin
                bus_if.ack   = force_ack;
                bus_if.rdata = force_rdata;
                bus_if.err   = force_err;
                wcnt = 0;
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) chk("bus_no_rereq_after_ack", 32'(bus_if.req), 32'd0);
                bus_if.ack = 1'b0;
                bus_if.err = 1'b0;
                if (bus_if.req) begin
                    if (wcnt < slave_waits) begin
                        wcnt++;
                    end else begin
                        bus_if.ack   = 1'b1;
                        bus_if.rdata = slave_word;
                        bus_if.err   = slave_err;
                        wcnt = 0;
                        if (bus_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL bus_unexpected_req: got req=1 addr=0x%08h required no request", bus_if.addr);
                        end else begin
                            e = bus_q.pop_front();
                            chk("bus_addr", bus_if.addr, e.addr);
                            chk("bus_be", 32'(bus_if.be), 32'(e.be));
                            chk("bus_rnw", 32'(bus_if.rnw), 32'(e.rnw));
                            if (e.chk_wdata) chk("bus_wdata", bus_if.wdata, e.wdata);
                        end
                    end
                end else begin
                    wcnt = 0;
                end
                prev_ack = bus_if.ack;
            end
        end
    end

    // Result monitor: when a port's busy falls, compare against its queue.
    initial begin
        int   bcnt [2];
        logic bprev [2];
        bcnt[0] = 0; bcnt[1] = 0;
        bprev[0] = 1'b0; bprev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                logic        b, ea, eb, have;
                logic [31:0] rd;
                res_t        e;
                b  = (p == 1) ? d_busy : f_busy;
                ea = (p == 1) ? d_err_align : f_err_align;
                eb = (p == 1) ? d_err_bus : f_err_bus;
                rd = (p == 1) ? d_rdata : f_rdata;
                if (b) begin
                    bcnt[p]++;
                end else if (bprev[p]) begin
                    have = 1'b0;
                    if (p == 1 && res_d.size() > 0) begin
                        e = res_d.pop_front();
                        have = 1'b1;
                    end else if (p == 0 && res_f.size() > 0) begin
                        e = res_f.pop_front();
                        have = 1'b1;
                    end
                    if (have) begin
                        chk((p == 1) ? "d_rdata" : "f_rdata", rd, e.rdata);
                        chk((p == 1) ? "d_err_align" : "f_err_align", 32'(ea), 32'(e.align));
                        chk((p == 1) ? "d_err_bus" : "f_err_bus", 32'(eb), 32'(e.bus_err));
                        if (e.busy != 0) chk((p == 1) ? "d_busy_cycles" : "f_busy_cycles", 32'(bcnt[p]), 32'(e.busy));
                    end
                    bcnt[p] = 0;
                end
                if ((ea || eb) && !(bprev[p] && !b)) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL err_pulse_port%0d: got align=%0b bus=%0b required 0 outside completion", p, ea, eb);
                end
                bprev[p] = b;
            end
        end
    end

    task automatic drive(input logic p, input logic [1:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rnw);
        if (p == PORT_D) begin
            d_cmd = cmd; d_addr = addr; d_wdata = wdata; d_rnw = rnw;
        end else begin
            f_cmd = cmd; f_addr = addr; f_wdata = wdata; f_rnw = rnw;
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while ((res_f.size() + res_d.size()) != 0 && t < 40) begin
            @(posedge clk);
            t++;
        end
        n_checks++;
        if ((res_f.size() + res_d.size()) != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d results pending required 0", tag, res_f.size() + res_d.size());
            res_f.delete();
            res_d.delete();
            bus_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [12];

    initial begin
        vec_t v;
        res_t r;

        vecs[0]  = '{PORT_D, CPU_LSU_WORD,  32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 3};
        vecs[1]  = '{PORT_D, CPU_LSU_BYTE,  32'h103, 32'h0,        1'b1, 32'h8899AABB, 0, 1'b0, 4'b1000, 32'h0,        32'h00000088, 1'b0, 1'b0, 3};
        vecs[2]  = '{PORT_D, CPU_LSU_HWORD, 32'h102, 32'hFFFF1234, 1'b0, 32'h0,        0, 1'b0, 4'b1100, 32'h12341234, 32'h00000088, 1'b0, 1'b0, 3};
        vecs[3]  = '{PORT_D, CPU_LSU_WORD,  32'h101, 32'h0,        1'b1, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h00000088, 1'b1, 1'b0, 1};
        vecs[4]  = '{PORT_D, CPU_LSU_HWORD, 32'h203, 32'h0,        1'b1, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h00000088, 1'b1, 1'b0, 1};
        vecs[5]  = '{PORT_F, CPU_LSU_HWORD, 32'h202, 32'h0,        1'b1, 32'hCAFEF00D, 1, 1'b0, 4'b1100, 32'h0,        32'h0000CAFE, 1'b0, 1'b0, 4};
        vecs[6]  = '{PORT_F, CPU_LSU_BYTE,  32'h301, 32'h0,        1'b1, 32'h11223344, 2, 1'b0, 4'b0010, 32'h0,        32'h00000033, 1'b0, 1'b0, 5};
        vecs[7]  = '{PORT_D, CPU_LSU_BYTE,  32'h003, 32'h123456A5, 1'b0, 32'h0,        0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h00000088, 1'b0, 1'b0, 3};
        vecs[8]  = '{PORT_D, CPU_LSU_WORD,  32'h040, 32'h01020304, 1'b0, 32'h0,        0, 1'b1, 4'b1111, 32'h01020304, 32'h00000088, 1'b0, 1'b1, 3};
        vecs[9]  = '{PORT_F, CPU_LSU_WORD,  32'h000, 32'h0,        1'b1, 32'h55AA55AA, 0, 1'b1, 4'b1111, 32'h0,        32'h00000033, 1'b0, 1'b1, 3};
        vecs[10] = '{PORT_F, CPU_LSU_HWORD, 32'h200, 32'h0,        1'b1, 32'h1234BEEF, 0, 1'b0, 4'b0011, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 3};
        vecs[11] = '{PORT_D, CPU_LSU_BYTE,  32'h100, 32'h0,        1'b1, 32'h8899AABB, 0, 1'b0, 4'b0001, 32'h0,        32'h000000BB, 1'b0, 1'b0, 3};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_if.req), 32'd0);
        chk("rst_bus_addr", bus_if.addr, 32'd0);
        chk("rst_bus_be", 32'(bus_if.be), 32'd0);
        chk("rst_bus_rnw", 32'(bus_if.rnw), 32'd0);
        chk("rst_bus_wdata", bus_if.wdata, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_errs", 32'({f_err_align, d_err_align, f_err_bus, d_err_bus}), 32'd0);
        chk("rst_busy", 32'({f_busy, d_busy}), 32'd0);
        nrst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            slave_waits = v.waits;
            slave_word  = v.bus_word;
            slave_err   = v.bus_err;
            if (!v.exp_align) bus_q.push_back('{v.addr & ~32'h3, v.exp_be, v.rnw, v.exp_bus_wdata, !v.rnw});
            r = '{v.exp_rdata, v.exp_align, v.exp_bus_err, v.exp_busy};
            if (v.port == PORT_D) res_d.push_back(r);
            else res_f.push_back(r);
            @(posedge clk);
            #1;
            $display("txn %0d: port=%0d cmd=%0d addr=0x%08h wdata=0x%08h rnw=%0b waits=%0d",
                     i, v.port, v.cmd, v.addr, v.wdata, v.rnw, v.waits);
            drive(v.port, v.cmd, v.addr, v.wdata, v.rnw);
            @(posedge clk);
            #1;
            drive(v.port, CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
            wait_done("vec");
            @(posedge clk);
        end

        // Simultaneous fetch and data reads, 2-wait slave; last grant was data.
        slave_waits = 2;
        slave_word  = 32'h0BADF00D;
        slave_err   = 1'b0;
`ifdef CPU_ARB_RR_EN
        bus_q.push_back('{32'h500, 4'b1111, 1'b1, 32'h0, 1'b0});
        bus_q.push_back('{32'h600, 4'b1111, 1'b1, 32'h0, 1'b0});
        res_f.push_back('{32'h0BADF00D, 1'b0, 1'b0, 5});
        res_d.push_back('{32'h0BADF00D, 1'b0, 1'b0, 9});
`else
        bus_q.push_back('{32'h600, 4'b1111, 1'b1, 32'h0, 1'b0});
        bus_q.push_back('{32'h500, 4'b1111, 1'b1, 32'h0, 1'b0});
        res_d.push_back('{32'h0BADF00D, 1'b0, 1'b0, 5});
        res_f.push_back('{32'h0BADF00D, 1'b0, 1'b0, 9});
`endif
        @(posedge clk);
        #1;
        $display("txn contention: f LW 0x500 and d LW 0x600 in the same cycle, 2 waits");
        drive(PORT_F, CPU_LSU_WORD, 32'h500, 32'h0, 1'b1);
        drive(PORT_D, CPU_LSU_WORD, 32'h600, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        drive(PORT_F, CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive(PORT_D, CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        wait_done("contention");
        @(posedge clk);

        // Reset during a fetch wait state, then a late ack that must be ignored.
        slave_en = 1'b0;
        @(posedge clk);
        #1;
        $display("txn abort: f LW 0x700, reset while waiting, late ack");
        drive(PORT_F, CPU_LSU_WORD, 32'h700, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        drive(PORT_F, CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("abort_req_up", 32'(bus_if.req), 32'd1);
        chk("abort_req_addr", bus_if.addr, 32'h700);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        chk("abort_req_dropped", 32'(bus_if.req), 32'd0);
        chk("abort_f_busy", 32'(f_busy), 32'd0);
        chk("abort_d_busy", 32'(d_busy), 32'd0);
        chk("abort_f_rdata_rst", f_rdata, 32'd0);
        force_ack   = 1'b1;
        force_err   = 1'b1;
        force_rdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        force_err = 1'b0;
        chk("late_ack_req", 32'(bus_if.req), 32'd0);
        chk("late_ack_f_busy", 32'(f_busy), 32'd0);
        chk("late_ack_f_rdata", f_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_f_err_bus", 32'(f_err_bus), 32'd0);
        chk("late_ack_req_after", 32'(bus_if.req), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single system bus between the instruction-fetch LSU port and the data LSU port driven by the memory-access stage. Accepts one-cycle LSU command pulses, holds the requester stalled via `busy`, checks alignment, steers byte lanes, runs a req/ack bus transaction and returns right-aligned read data. Sits between the pipeline's fetch and memory stages and the top-level bus interface.

## Interface
- `CPU_ADDR_WIDTH` (from `cpu_common.vh`), 32: address width.
- `CPU_DATA_WIDTH` (from `cpu_common.vh`), 32: data width; lane logic is fixed to 4 byte lanes.
- `clk`  in  1  clock; one clock, all state on rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `i_<p>_addr`  in  ADDR  request address; `<p>` ∈ {`f` fetch, `d` data}, identical port sets.
- `i_<p>_wdata`  in  DATA  right-aligned write data.
- `i_<p>_cmd`  in  2  `CPU_LSU_IDLE`/`BYTE`/`HWORD`/`WORD`; non-IDLE for exactly one cycle per request.
- `i_<p>_rnw`  in  1  1 = read, 0 = write.
- `o_<p>_rdata`  out  DATA  right-aligned read data, upper unused bits zero; held until the next read completes on that port.
- `o_<p>_busy`  out  1  combinational: `(i_<p>_cmd != IDLE) | pend_<p>`.
- `o_<p>_err_align`  out  1  one-cycle pulse.
- `o_<p>_err_bus`  out  1  one-cycle pulse.
- `o_bus_req`  out  1  transaction request, held until ack.
- `o_bus_addr`  out  ADDR  word address, `[1:0]` = 0.
- `o_bus_be`  out  4  byte enables.
- `o_bus_rnw`  out  1  direction.
- `o_bus_wdata`  out  DATA  lane-replicated write data.
- `i_bus_ack`  in  1  one-cycle completion; `rdata`/`err` valid with it.
- `i_bus_rdata`  in  DATA  read word.
- `i_bus_err`  in  1  bus error, qualified by ack.

## Operation
- Per port, on an edge where `cmd != IDLE` and `pend_<p>` = 0, the arbiter checks alignment. A misaligned request is HWORD with `addr[0]`, or WORD with `addr[1:0] != 0`. Misaligned: no pending entry, `err_align` = 1 for the following cycle. Otherwise it latches `addr`/`wdata`/`cmd`/`rnw` and sets `pend_<p>`.
- A cmd arriving while `pend_<p>` = 1 is a protocol violation and is ignored.
- FSM states:
  - IDLE: if any `pend` is set, go to BUS_D or BUS_F per the arbitration policy.
  - BUS_D / BUS_F: drive the bus from that port's latch with `o_bus_req` = 1. On `i_bus_ack`: clear `pend`; on a read, capture the aligned `rdata`; if `i_bus_err`, pulse `err_bus` next cycle (`rdata` not updated). Return to IDLE.
- Lanes are little-endian, with `k = addr[1:0]`:
  - BYTE: `be = 4'b0001 << k`, `wdata` = byte ×4.
  - HWORD: `be = 4'b0011 << k`, `wdata` = half ×2.
  - WORD: `be = 4'b1111`.
  - Read: `rdata = i_bus_rdata >> 8k`, masked to 8/16/32 bits.
- Reset (`nrst` low at an edge) clears both `pend`, FSM→IDLE, `o_bus_req`/errors/`rdata` → 0. An in-flight bus transaction is abandoned; a late ack in IDLE is ignored.

## Timing
- Reset values: `o_bus_req`=0, `o_bus_addr`=0, `o_bus_be`=0, `o_bus_rnw`=0, `o_bus_wdata`=0, `rdata`=0, `err_*`=0. `busy` follows its combinational equation (0 when cmd is IDLE).
- Zero-wait slave, with cmd visible in cycle C0:
  - edge0 latches; C1 IDLE arbitrates; edge1 → BUS.
  - C2: `req` high and ack.
  - edge2 completes; C3 `busy` = 0 and `rdata` valid.
  - `busy` is therefore high for C0–C2.
- Each wait state from the slave adds one cycle.
- Misaligned: `busy` is high only in C0; C1 has `err_align` = 1 and `busy` = 0.
- `o_bus_*` are stable while `req` = 1. `req` drops in the cycle after ack. The bus is never re-requested in the cycle after ack, because the FSM passes through IDLE.

## Configuration
- `CPU_ARB_RR_EN` defined: round-robin between ports. A 1-bit `last` register is updated on each grant. On simultaneous pending requests in IDLE, the port not granted last wins.
- Undefined: fixed priority, data port wins whenever `pend_d` is set in IDLE. The `last` register is not present.

## Structure
- `cpu_const.vh`:
  - existing `CPU_LSU_IDLE/BYTE/HWORD/WORD`;
  - new FSM state codes `CPU_ARB_IDLE`, `CPU_ARB_BUS_F`, `CPU_ARB_BUS_D`;
  - port-select constants.
- One combinational sub-module `bus_lane_align`: (cmd, addr[1:0], wdata, bus_rdata) → (be, bus_wdata, rdata).
- Request latching is instantiated per port inside `mem_bus_arbiter`.

## Test plan
- Data LW read at 0x100, slave returns 0xDEADBEEF with 0 wait: `be`=1111, `o_d_busy` high 3 cycles, `o_d_rdata`=0xDEADBEEF.
- LB at 0x103, bus word 0x8899AABB: `be`=1000, `o_d_rdata`=0x00000088. SH wdata 0x1234 at 0x102: `be`=1100, `o_bus_wdata`=0x12341234.
- LW at 0x101: no `o_bus_req`, `o_d_err_align` pulses once in C1. LH at 0x203 behaves the same.
- Fetch and data requests in the same cycle, 2-wait slave:
  - without `CPU_ARB_RR_EN`: data granted first, fetch is served after it.
  - with the macro and last grant = D: fetch granted first.
- SW with ack+`i_bus_err`: `o_d_err_bus` one-cycle pulse, `busy` drops, `o_d_rdata` unchanged. Then `nrst` low during a BUS_F wait: `req`=0 next cycle, both `busy` = 0, later ack ignored.
